// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the CPU datapath and a byte-enabled, word-wide data RAM.
// Optional feature: define MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they return resp_err.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_CAP, S_RESP} state_t;

    state_t      r_state, w_next_state;
    logic        r_we, r_split;
    logic [2:0]  r_memop;
    logic [1:0]  r_k;
    logic [3:0]  r_hi_mask;
    logic [31:0] r_word0;
    logic [31:0] r_mem_addr, r_mem_wdata, r_resp_rdata;
    logic        r_mem_we, r_resp_err;
    logic [3:0]  r_mem_wmask;

    logic        w_hs, w_legal, w_split, w_err;
    logic [2:0]  w_nbytes;
    logic [3:0]  w_base_mask;
    logic [7:0]  w_lane8;
    logic [31:0] w_wdata_rot;
    logic [63:0] w_dword;
    logic [31:0] w_shifted, w_load_data;

    // Request decode, evaluated on the live request inputs during IDLE.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        w_nbytes    = 3'd4;
        w_base_mask = 4'b1111;
        w_wdata_rot = req_wdata;
        if (req_we)
            w_legal = (req_memop == 3'b000) || (req_memop == 3'b001) || (req_memop == 3'b010);
        else
            w_legal = !((req_memop == 3'b011) || (req_memop[2:1] == 2'b11));
        case (req_memop[1:0])
            2'b00:   begin w_nbytes = 3'd1; w_base_mask = 4'b0001; end
            2'b01:   begin w_nbytes = 3'd2; w_base_mask = 4'b0011; end
            default: ;
        endcase
        w_split = ({1'b0, req_addr[1:0]} + w_nbytes) > 3'd4;
`ifdef MISALIGN_SPLIT_EN
        w_err = !w_legal;
`else
        w_err = !w_legal || w_split;
`endif
        // Low nibble: lanes in the first word; high nibble: lanes spilling into the next word.
        w_lane8 = {4'b0000, w_base_mask} << req_addr[1:0];
        case (req_addr[1:0])
            2'd1:    w_wdata_rot = {req_wdata[23:0], req_wdata[31:24]};
            2'd2:    w_wdata_rot = {req_wdata[15:0], req_wdata[31:16]};
            2'd3:    w_wdata_rot = {req_wdata[7:0],  req_wdata[31:8]};
            default: ;
        endcase
    end

    // Load extraction from one or two captured words.
    always_comb begin
        w_dword   = r_split ? {mem_rdata, r_word0} : {32'b0, mem_rdata};
        w_shifted = 32'(w_dword >> {r_k, 3'b000});
        case (r_memop)
            3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'b0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'b0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = (r_state == S_IDLE);
        resp_valid   = (r_state == S_RESP);
        w_hs         = req_valid && req_ready;
        case (r_state)
            S_IDLE:  if (w_hs) w_next_state = w_err ? S_RESP : S_ACC0;
            S_ACC0:  w_next_state = r_split ? S_ACC1 : S_CAP;
            S_ACC1:  w_next_state = S_CAP;
            S_CAP:   w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // RAM-side outputs are registered one state ahead so they are stable for the whole access cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we         <= 1'b0;
            r_split      <= 1'b0;
            r_memop      <= 3'b000;
            r_k          <= 2'b00;
            r_hi_mask    <= 4'b0000;
            r_word0      <= 32'b0;
            r_mem_addr   <= 32'b0;
            r_mem_wdata  <= 32'b0;
            r_mem_we     <= 1'b0;
            r_mem_wmask  <= 4'b0000;
            r_resp_rdata <= 32'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_hs) begin
                    r_we      <= req_we;
                    r_memop   <= req_memop;
                    r_k       <= req_addr[1:0];
                    r_split   <= w_split;
                    r_hi_mask <= w_lane8[7:4];
                    if (w_err) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'b0;
                    end else begin
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_wdata <= w_wdata_rot;
                        r_mem_we    <= req_we;
                        r_mem_wmask <= req_we ? w_lane8[3:0] : 4'b0000;
                    end
                end
                S_ACC0: if (r_split) begin
                    r_mem_addr  <= r_mem_addr + 32'd4;
                    r_mem_wmask <= r_we ? r_hi_mask : 4'b0000;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_wmask <= 4'b0000;
                end
                S_ACC1: begin
                    r_word0     <= mem_rdata;
                    r_mem_we    <= 1'b0;
                    r_mem_wmask <= 4'b0000;
                end
                S_CAP: begin
                    r_resp_rdata <= r_we ? 32'b0 : w_load_data;
                    r_resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wmask  = r_mem_wmask;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized requests against a byte-level memory model.
`timescale 1ns/1ps
module tb_lsu_ctrl;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_memop = 3'b000;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'b0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // RAM seen by the DUT, and the reference byte store predicted from requests alone.
    bit [7:0] ram   [bit [31:0]];
    bit [7:0] model [bit [31:0]];

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic bit [7:0] model_rd(input bit [31:0] a);
        return model.exists(a) ? model[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ram[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
        mem_rdata <= {ram_rd(mem_addr + 32'd3), ram_rd(mem_addr + 32'd2),
                      ram_rd(mem_addr + 32'd1), ram_rd(mem_addr)};
    end

    function automatic int unsigned op_size(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit op_legal(input logic we, input logic [2:0] op);
        if (we) return (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101);
    endfunction

    logic [31:0] snap_addr  [1:12];
    logic [31:0] snap_wdata [1:12];
    logic [3:0]  snap_mask  [1:12];
    logic        snap_we    [1:12];

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rd);
        int unsigned n;
        bit          split, err;
        int          exp_lat, lat;
        bit          seen;
        logic [63:0] val;
        n       = op_size(op);
        split   = (32'(addr[1:0]) + n) > 32'd4;
        err     = !op_legal(we, op) || (split && !SPLIT_EN);
        exp_lat = err ? 1 : (split ? 4 : 3);
        val     = 64'b0;
        if (!we && !err) begin
            for (int unsigned i = 0; i < n; i++) val[8*i +: 8] = model_rd(addr + 32'(i));
            if (!op[2] && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
        end
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
        lat = 0; seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            snap_addr[lat] = mem_addr; snap_wdata[lat] = mem_wdata;
            snap_mask[lat] = mem_wmask; snap_we[lat] = mem_we;
            if (resp_valid) seen = 1'b1;
            else check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
            if (!we || err) check({tag, ".no_write"}, 32'(mem_we), 32'd0);
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, 32'(resp_err), 32'(err));
        check({tag, ".rdata"}, resp_rdata, (we || err) ? 32'b0 : val[31:0]);
        rd = resp_rdata;
        if (we && !err)
            for (int unsigned i = 0; i < n; i++) model[addr + 32'(i)] = wdata[8*i +: 8];
    endtask

    task automatic check_reset_vals(input string p);
        check({p, ".req_ready"},  32'(req_ready),  32'd1);
        check({p, ".resp_valid"}, 32'(resp_valid), 32'd0);
        check({p, ".resp_rdata"}, resp_rdata,      32'd0);
        check({p, ".resp_err"},   32'(resp_err),   32'd0);
        check({p, ".mem_we"},     32'(mem_we),     32'd0);
        check({p, ".mem_wmask"},  32'(mem_wmask),  32'd0);
        check({p, ".mem_addr"},   mem_addr,        32'd0);
        check({p, ".mem_wdata"},  mem_wdata,       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          cnt;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("por_rel");

        do_req("sw100", 1'b1, 3'b010, 32'h100, 32'h11223344, rd);
        check("sw100.we",    32'(snap_we[1]),   32'd1);
        check("sw100.mask",  32'(snap_mask[1]), 32'hF);
        check("sw100.addr",  snap_addr[1],      32'h100);
        check("sw100.wdata", snap_wdata[1],     32'h11223344);
        do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, rd);
        check("lw100.const", rd, 32'h11223344);

        do_req("sw100b", 1'b1, 3'b010, 32'h100, 32'h80FF7F01, rd);
        do_req("lb103",  1'b0, 3'b000, 32'h103, 32'h0, rd);
        check("lb103.const", rd, 32'hFFFFFF80);
        do_req("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, rd);
        check("lbu103.const", rd, 32'h00000080);
        do_req("lh102",  1'b0, 3'b001, 32'h102, 32'h0, rd);
        check("lh102.const", rd, 32'hFFFF80FF);
        do_req("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, rd);
        check("lhu100.const", rd, 32'h00007F01);
        do_req("sb101",  1'b1, 3'b000, 32'h101, 32'h000000A5, rd);
        check("sb101.mask",  32'(snap_mask[1]), 32'b0010);
        check("sb101.wdata", snap_wdata[1],     32'h0000A500);

`ifdef MISALIGN_SPLIT_EN
        do_req("swsplit", 1'b1, 3'b010, 32'h102, 32'hAABBCCDD, rd);
        check("swsplit.addr0",  snap_addr[1],      32'h100);
        check("swsplit.mask0",  32'(snap_mask[1]), 32'b1100);
        check("swsplit.wdata0", snap_wdata[1],     32'hCCDDAABB);
        check("swsplit.addr1",  snap_addr[2],      32'h104);
        check("swsplit.mask1",  32'(snap_mask[2]), 32'b0011);
        check("swsplit.wdata1", snap_wdata[2],     32'hCCDDAABB);
        check("swsplit.we1",    32'(snap_we[2]),   32'd1);
        do_req("lwsplit", 1'b0, 3'b010, 32'h102, 32'h0, rd);
        check("lwsplit.const", rd, 32'hAABBCCDD);
        do_req("shwrap", 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, rd);
        check("shwrap.addr0",  snap_addr[1],      32'hFFFFFFFC);
        check("shwrap.mask0",  32'(snap_mask[1]), 32'b1000);
        check("shwrap.addr1",  snap_addr[2],      32'h00000000);
        check("shwrap.mask1",  32'(snap_mask[2]), 32'b0001);
        check("shwrap.wdata",  snap_wdata[2],     32'hEF0000BE);
        do_req("lhuwrap", 1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, rd);
        check("lhuwrap.const", rd, 32'h0000BEEF);
`else
        do_req("lw101", 1'b0, 3'b010, 32'h101, 32'h0, rd);
        check("lw101.err",   32'(resp_err), 32'd1);
        check("lw101.const", rd,            32'h0);
        do_req("sw103", 1'b1, 3'b010, 32'h103, 32'h12345678, rd);
        check("sw103.err", 32'(resp_err), 32'd1);
`endif

        do_req("ld111", 1'b0, 3'b111, 32'h100, 32'h0, rd);
        check("ld111.err", 32'(resp_err), 32'd1);
        do_req("st100", 1'b1, 3'b100, 32'h100, 32'hDEADBEEF, rd);
        check("st100.err", 32'(resp_err), 32'd1);

        // Reset in the middle of an access: no response, outputs back to reset values.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h106; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst.acc0_we",   32'(mem_we),    32'd1);
        check("rst.acc0_mask", 32'(mem_wmask), 32'b1100);
        @(negedge clk);
        check("rst.acc1_addr", mem_addr,       32'h108);
        check("rst.acc1_mask", 32'(mem_wmask), 32'b0011);
`else
        req_addr = 32'h10C; req_wdata = 32'h55667788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst.acc0_we", 32'(mem_we), 32'd1);
`endif
        rstn = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        check("rst.no_resp", 32'(cnt), 32'd0);
`ifdef MISALIGN_SPLIT_EN
        model[32'h106] = 8'h88;
        model[32'h107] = 8'h77;
        do_req("rst_lw104", 1'b0, 3'b010, 32'h104, 32'h0, rd);
        check("rst_lw104.const", rd, 32'h7788AABB);
        do_req("rst_lw108", 1'b0, 3'b010, 32'h108, 32'h0, rd);
        check("rst_lw108.const", rd, 32'h00000000);
`else
        do_req("rst_lw10c", 1'b0, 3'b010, 32'h10C, 32'h0, rd);
        check("rst_lw10c.const", rd, 32'h00000000);
`endif

        for (int t = 0; t < 400; t++) begin
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            if (we && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 2));
            if (!we && (op == 3'b011 || op[2:1] == 2'b11) && $urandom_range(0, 3) != 0) op = 3'b010;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
            else                           addr = 32'h100 + 32'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req($sformatf("rnd%0d", t), we, op, addr, $urandom(), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
